ext_axi_arbiter_n: RTL and testbench
====================================

EXT_AXI_ARBITER_N -- requirements
Module: ext_axi_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2; number of upstream AXI masters, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32; address width.
REQ-003 SHALL have parameter DATA_W, default 32; data width; wstrb is DATA_W/8.
REQ-004 SHALL have parameter ID_W, default 4; upstream ID width; IDX_W = $clog2(NUM_MASTERS).
REQ-005 SHALL have port clk, input, 1; clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset, synchronous, active-low.
REQ-007 SHALL have ports s_aw{id,addr,len,size,burst,valid}, input, NUM_MASTERS x {ID_W,ADDR_W,8,3,2,1}; per-master write address.
REQ-008 SHALL have ports s_w{data,strb,last,valid}, input, NUM_MASTERS x {DATA_W,DATA_W/8,1,1}; per-master write data.
REQ-009 SHALL have ports s_ar{id,addr,len,size,burst,valid}, input, NUM_MASTERS x {ID_W,ADDR_W,8,3,2,1}; per-master read address.
REQ-010 SHALL have ports s_bready and s_rready, input, NUM_MASTERS x 1; per-master response ready.
REQ-011 SHALL have ports s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_rlast, output, NUM_MASTERS x 1; per-master handshakes.
REQ-012 SHALL have ports s_bid/s_bresp and s_rid/s_rdata/s_rresp, output, NUM_MASTERS x {ID_W,2} and {ID_W,DATA_W,2}; per-master responses.
REQ-013 SHALL have ports m_*, one single AXI4 master port with the same field set; m_awid and m_arid are ID_W+IDX_W wide, as {grant_idx, s_id}.
REQ-014 SHALL have port grant_idx, output, IDX_W; index of the master currently owning the bus.
REQ-015 SHALL have port busy, output, 1; high in any state other than IDLE.

Function
REQ-016 SHALL implement the states IDLE, RD and WR.
REQ-017 In IDLE, master i SHALL be counted as requesting when s_arvalid[i] or s_awvalid[i] is high.
REQ-018 In IDLE with at least one requester, the FSM SHALL latch the winner into grant_idx and move to RD if the winner's arvalid is high, otherwise to WR; when both are high, read wins.
REQ-019 Grant latency SHALL be one cycle; in IDLE all m_*valid, m_*ready and s_* outputs SHALL be 0.
REQ-020 In RD, the AR and R channels of the granted master SHALL be routed combinationally to/from m_*; AW, W and B to m_* SHALL be held at 0.
REQ-021 In RD, the R-channel id SHALL be returned as m_rid[ID_W-1:0] to the granted master only.
REQ-022 In RD, the FSM SHALL return to IDLE on the cycle m_rvalid & m_rready & m_rlast is seen.
REQ-023 In WR, the AW, W and B channels of the granted master SHALL be routed combinationally; AR and R SHALL be held at 0.
REQ-024 In WR, the FSM SHALL return to IDLE on m_bvalid & m_bready.
REQ-025 Non-granted masters SHALL see every ready/valid output at 0 and every data output at 0, regardless of state.
REQ-026 Requests arriving while busy SHALL simply be held by their masters; none SHALL be dropped or partially forwarded.
REQ-027 A new grant SHALL NOT occur earlier than the cycle after release; back-to-back transactions therefore cost one IDLE cycle.
REQ-028 An m_rid or m_bid whose upper IDX_W bits differ from grant_idx SHALL still be routed to grant_idx.

Reset
REQ-029 On rst_n low at a clock edge, the FSM SHALL go to IDLE, grant_idx SHALL go to 0, busy SHALL go to 0, and the round-robin pointer SHALL go to NUM_MASTERS-1.
REQ-030 All m_* and s_* valid/ready outputs SHALL read 0 in the cycle after reset.
REQ-031 Reset mid-transaction SHALL abandon the in-flight transfer; no state is retained.

Configuration
REQ-032 With macro ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requester searching from pointer+1 upward with wrap-around, and the pointer SHALL update to the winner on each grant.
REQ-033 Without ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority (lowest index wins) and the pointer logic SHALL be absent.

Verification
REQ-034 The bench SHALL cover: NUM_MASTERS=4, only master 2 asserts arvalid, arlen=3 -> grant_idx=2, m_arid={2'd2,s_arid}, 4 R beats delivered to master 2 only, busy drops the cycle after the rlast handshake.
REQ-035 The bench SHALL cover: masters 0 and 1 assert arvalid simultaneously with ARB_ROUND_ROBIN_EN -> grants in order 0, 1, 0, 1; without the macro -> 0, 0, 0.
REQ-036 The bench SHALL cover: master 1 asserts awvalid and arvalid in the same cycle -> RD first, then WR after one IDLE cycle.
REQ-037 The bench SHALL cover: a write with awlen=1 and m_bvalid delayed 10 cycles -> master 0 stays blocked with arready=0 until the B handshake completes.
REQ-038 The bench SHALL cover: rst_n asserted during the second of 4 R beats -> the next cycle has busy=0, grant_idx=0, and all valids 0.

Source files
------------

// File: rtl/ext_axi_arbiter_n.sv
// N-to-1 AXI4 arbiter: one whole transaction (read or write) owns the master port at a time.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed lowest-index priority.
module ext_axi_arbiter_n #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    localparam int IDX_W      = $clog2(NUM_MASTERS),
    localparam int STRB_W     = DATA_W / 8,
    localparam int MID_W      = ID_W + IDX_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    // upstream write address
    input  logic [NUM_MASTERS-1:0][ID_W-1:0]     s_awid,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   s_awaddr,
    input  logic [NUM_MASTERS-1:0][7:0]          s_awlen,
    input  logic [NUM_MASTERS-1:0][2:0]          s_awsize,
    input  logic [NUM_MASTERS-1:0][1:0]          s_awburst,
    input  logic [NUM_MASTERS-1:0]               s_awvalid,
    output logic [NUM_MASTERS-1:0]               s_awready,
    // upstream write data
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]   s_wdata,
    input  logic [NUM_MASTERS-1:0][STRB_W-1:0]   s_wstrb,
    input  logic [NUM_MASTERS-1:0]               s_wlast,
    input  logic [NUM_MASTERS-1:0]               s_wvalid,
    output logic [NUM_MASTERS-1:0]               s_wready,
    // upstream write response
    output logic [NUM_MASTERS-1:0][ID_W-1:0]     s_bid,
    output logic [NUM_MASTERS-1:0][1:0]          s_bresp,
    output logic [NUM_MASTERS-1:0]               s_bvalid,
    input  logic [NUM_MASTERS-1:0]               s_bready,
    // upstream read address
    input  logic [NUM_MASTERS-1:0][ID_W-1:0]     s_arid,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   s_araddr,
    input  logic [NUM_MASTERS-1:0][7:0]          s_arlen,
    input  logic [NUM_MASTERS-1:0][2:0]          s_arsize,
    input  logic [NUM_MASTERS-1:0][1:0]          s_arburst,
    input  logic [NUM_MASTERS-1:0]               s_arvalid,
    output logic [NUM_MASTERS-1:0]               s_arready,
    // upstream read data
    output logic [NUM_MASTERS-1:0][ID_W-1:0]     s_rid,
    output logic [NUM_MASTERS-1:0][DATA_W-1:0]   s_rdata,
    output logic [NUM_MASTERS-1:0][1:0]          s_rresp,
    output logic [NUM_MASTERS-1:0]               s_rlast,
    output logic [NUM_MASTERS-1:0]               s_rvalid,
    input  logic [NUM_MASTERS-1:0]               s_rready,
    // downstream master port
    output logic [MID_W-1:0]                     m_awid,
    output logic [ADDR_W-1:0]                    m_awaddr,
    output logic [7:0]                           m_awlen,
    output logic [2:0]                           m_awsize,
    output logic [1:0]                           m_awburst,
    output logic                                 m_awvalid,
    input  logic                                 m_awready,
    output logic [DATA_W-1:0]                    m_wdata,
    output logic [STRB_W-1:0]                    m_wstrb,
    output logic                                 m_wlast,
    output logic                                 m_wvalid,
    input  logic                                 m_wready,
    input  logic [MID_W-1:0]                     m_bid,
    input  logic [1:0]                           m_bresp,
    input  logic                                 m_bvalid,
    output logic                                 m_bready,
    output logic [MID_W-1:0]                     m_arid,
    output logic [ADDR_W-1:0]                    m_araddr,
    output logic [7:0]                           m_arlen,
    output logic [2:0]                           m_arsize,
    output logic [1:0]                           m_arburst,
    output logic                                 m_arvalid,
    input  logic                                 m_arready,
    input  logic [MID_W-1:0]                     m_rid,
    input  logic [DATA_W-1:0]                    m_rdata,
    input  logic [1:0]                           m_rresp,
    input  logic                                 m_rlast,
    input  logic                                 m_rvalid,
    output logic                                 m_rready,
    output logic [IDX_W-1:0]                     grant_idx,
    output logic                                 busy
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic               busy_q;
    logic [IDX_W-1:0]   grant_d;
    logic               grant_found;
    logic [NUM_MASTERS-1:0] req;

    // Returned IDs are always steered by grant_q; their index field is informational only.
    logic unused_id_hi;
    assign unused_id_hi = ^{m_rid[MID_W-1:ID_W], m_bid[MID_W-1:ID_W]};

    assign req       = s_arvalid | s_awvalid;
    assign grant_idx = grant_q;
    assign busy      = busy_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    always_comb begin
        int cand;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        cand        = 0;
        grant_d     = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_d     = IDX_W'(cand);
            end
        end
    end
`else
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grant_d     = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!grant_found && req[i]) begin
                grant_found = 1'b1;
                grant_d     = IDX_W'(i);
            end
        end
    end
`endif

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= IDX_W'(NUM_MASTERS - 1);
`endif
        end else begin
            case (state_q)
                IDLE: if (grant_found) begin
                    grant_q <= grant_d;
                    busy_q  <= 1'b1;
                    state_q <= s_arvalid[grant_d] ? RD : WR;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_q   <= grant_d;
`endif
                end
                RD: if (m_rvalid && m_rready && m_rlast) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                WR: if (m_bvalid && m_bready) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Channel steering: only the owning master's channels of the active direction are connected.
    always_comb begin
        m_awid    = '0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_awburst = '0;
        m_awvalid = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_awready = '0;
        s_wready  = '0;
        s_bid     = '0;
        s_bresp   = '0;
        s_bvalid  = '0;
        s_arready = '0;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = '0;
        s_rvalid  = '0;
        case (state_q)
            RD: begin
                m_arid             = {grant_q, s_arid[grant_q]};
                m_araddr           = s_araddr[grant_q];
                m_arlen            = s_arlen[grant_q];
                m_arsize           = s_arsize[grant_q];
                m_arburst          = s_arburst[grant_q];
                m_arvalid          = s_arvalid[grant_q];
                s_arready[grant_q] = m_arready;
                m_rready           = s_rready[grant_q];
                s_rid[grant_q]     = m_rid[ID_W-1:0];
                s_rdata[grant_q]   = m_rdata;
                s_rresp[grant_q]   = m_rresp;
                s_rlast[grant_q]   = m_rlast;
                s_rvalid[grant_q]  = m_rvalid;
            end
            WR: begin
                m_awid             = {grant_q, s_awid[grant_q]};
                m_awaddr           = s_awaddr[grant_q];
                m_awlen            = s_awlen[grant_q];
                m_awsize           = s_awsize[grant_q];
                m_awburst          = s_awburst[grant_q];
                m_awvalid          = s_awvalid[grant_q];
                s_awready[grant_q] = m_awready;
                m_wdata            = s_wdata[grant_q];
                m_wstrb            = s_wstrb[grant_q];
                m_wlast            = s_wlast[grant_q];
                m_wvalid           = s_wvalid[grant_q];
                s_wready[grant_q]  = m_wready;
                m_bready           = s_bready[grant_q];
                s_bid[grant_q]     = m_bid[ID_W-1:0];
                s_bresp[grant_q]   = m_bresp;
                s_bvalid[grant_q]  = m_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ext_axi_arbiter_n.sv
// Directed bench for ext_axi_arbiter_n with four masters; arbitration expectations follow
// whether ARB_ROUND_ROBIN_EN is defined.
module tb_ext_axi_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int XW = 2;
    localparam int MW = IW + XW;

    logic clk;
    logic rst_n;

    logic [N-1:0][IW-1:0]   s_awid, s_arid, s_bid, s_rid;
    logic [N-1:0][AW-1:0]   s_awaddr, s_araddr;
    logic [N-1:0][7:0]      s_awlen, s_arlen;
    logic [N-1:0][2:0]      s_awsize, s_arsize;
    logic [N-1:0][1:0]      s_awburst, s_arburst, s_bresp, s_rresp;
    logic [N-1:0][DW-1:0]   s_wdata, s_rdata;
    logic [N-1:0][DW/8-1:0] s_wstrb;
    logic [N-1:0]           s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic [N-1:0]           s_bvalid, s_bready, s_arvalid, s_arready;
    logic [N-1:0]           s_rlast, s_rvalid, s_rready;

    logic [MW-1:0]   m_awid, m_arid, m_bid, m_rid;
    logic [AW-1:0]   m_awaddr, m_araddr;
    logic [7:0]      m_awlen, m_arlen;
    logic [2:0]      m_awsize, m_arsize;
    logic [1:0]      m_awburst, m_arburst, m_bresp, m_rresp;
    logic            m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic            m_bvalid, m_bready, m_arvalid, m_arready;
    logic            m_rlast, m_rvalid, m_rready;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [DW/8-1:0] m_wstrb;
    logic [XW-1:0]   grant_idx;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    ext_axi_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .grant_idx(grant_idx), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0]  arv;
        logic [N-1:0]  awv;
        logic [XW-1:0] g;
        logic          rd;
    } vec_t;

    vec_t vecs[7];
    int   rr_exp[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        s_awvalid = '0;
        s_wvalid  = '0;
        s_wlast   = '0;
        s_arvalid = '0;
        s_bready  = '1;
        s_rready  = '1;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        m_arready = 1'b1;
        m_bvalid  = 1'b0;
        m_bid     = '0;
        m_bresp   = '0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [MW-1:0] exp_ar;
        logic [MW-1:0] exp_aw;

        for (int i = 0; i < N; i++) begin
            s_awid[i]    = 4'(4 + i);
            s_arid[i]    = 4'(8 + i);
            s_awaddr[i]  = 32'h1000_0000 + 32'(i * 16'h100);
            s_araddr[i]  = 32'h2000_0000 + 32'(i * 16'h100);
            s_awlen[i]   = 8'd0;
            s_arlen[i]   = 8'd0;
            s_awsize[i]  = 3'd2;
            s_arsize[i]  = 3'd2;
            s_awburst[i] = 2'b01;
            s_arburst[i] = 2'b01;
            s_wdata[i]   = 32'hA0A0_0000 + 32'(i);
            s_wstrb[i]   = 4'hF;
        end

        vecs[0] = '{arv: 4'b0100, awv: 4'b0000, g: 2'd2, rd: 1'b1};
        vecs[1] = '{arv: 4'b0000, awv: 4'b1000, g: 2'd3, rd: 1'b0};
        vecs[2] = '{arv: 4'b0000, awv: 4'b0110, g: 2'd1, rd: 1'b0};
        vecs[3] = '{arv: 4'b1000, awv: 4'b0010, g: 2'd1, rd: 1'b0};
        vecs[4] = '{arv: 4'b0010, awv: 4'b0010, g: 2'd1, rd: 1'b1};
        vecs[5] = '{arv: 4'b1111, awv: 4'b0000, g: 2'd0, rd: 1'b1};
        vecs[6] = '{arv: 4'b0000, awv: 4'b0001, g: 2'd0, rd: 1'b0};

`ifdef ARB_ROUND_ROBIN_EN
        rr_exp = '{0, 1, 0, 1};
`else
        rr_exp = '{0, 0, 0};
`endif

        // Reset state
        do_reset();
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_idx), 64'd0);
        check("rst_m_valid_ready", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
        check("rst_s_valid_ready", 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 64'd0);

        // Arbitration vectors, each from a fresh reset
        for (int v = 0; v < 7; v++) begin
            do_reset();
            s_arvalid = vecs[v].arv;
            s_awvalid = vecs[v].awv;
            #1;
            check("vec_idle_ready", 64'({s_arready, s_awready, m_arvalid, m_awvalid}), 64'd0);
            step();
            exp_ar = {vecs[v].g, 4'(8 + vecs[v].g)};
            exp_aw = {vecs[v].g, 4'(4 + vecs[v].g)};
            check("vec_grant", 64'(grant_idx), 64'(vecs[v].g));
            check("vec_busy", 64'(busy), 64'd1);
            check("vec_m_arvalid", 64'(m_arvalid), 64'(vecs[v].rd));
            check("vec_m_awvalid", 64'(m_awvalid), 64'(!vecs[v].rd));
            check("vec_s_arready", 64'(s_arready), vecs[v].rd ? 64'(4'b1 << vecs[v].g) : 64'd0);
            check("vec_s_awready", 64'(s_awready), vecs[v].rd ? 64'd0 : 64'(4'b1 << vecs[v].g));
            check("vec_m_arid", 64'(m_arid), vecs[v].rd ? 64'(exp_ar) : 64'd0);
            check("vec_m_awid", 64'(m_awid), vecs[v].rd ? 64'd0 : 64'(exp_aw));
        end

        // Master 2 read burst of 4 beats
        do_reset();
        s_arvalid   = 4'b0100;
        s_arlen[2]  = 8'd3;
        step();
        check("rd4_grant", 64'(grant_idx), 64'd2);
        check("rd4_m_arid", 64'(m_arid), 64'h2A);
        check("rd4_m_araddr", 64'(m_araddr), 64'h2000_0200);
        check("rd4_m_arlen", 64'(m_arlen), 64'd3);
        step();
        s_arvalid = '0;
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'hD000_0000 + 32'(b);
            m_rid    = (b == 2) ? {2'd1, 4'hA} : {2'd2, 4'hA};
            m_rlast  = (b == 3);
            m_rresp  = 2'b00;
            if (b == 3) begin
                s_rready = 4'b1011;
                #1;
                check("rd4_stall_rready", 64'(m_rready), 64'd0);
                step();
                check("rd4_stall_busy", 64'(busy), 64'd1);
                s_rready = 4'b1111;
            end
            #1;
            check("rd4_s_rvalid", 64'(s_rvalid), 64'b0100);
            check("rd4_s_rdata", 64'(s_rdata[2]), 64'(32'hD000_0000 + 32'(b)));
            check("rd4_other_rdata", 64'(s_rdata[0] | s_rdata[1] | s_rdata[3]), 64'd0);
            check("rd4_s_rid", 64'(s_rid[2]), 64'hA);
            check("rd4_s_rlast", 64'(s_rlast), (b == 3) ? 64'b0100 : 64'd0);
            check("rd4_m_rready", 64'(m_rready), 64'd1);
            step();
            if (b < 3) check("rd4_busy_mid", 64'(busy), 64'd1);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        check("rd4_busy_drop", 64'(busy), 64'd0);
        check("rd4_idle_rvalid", 64'(s_rvalid), 64'd0);
        s_arlen[2] = 8'd0;

        // Masters 0 and 1 contend continuously
        do_reset();
        s_arvalid = 4'b0011;
        step();
        for (int t = 0; t < rr_exp.size(); t++) begin
            check("arb_busy", 64'(busy), 64'd1);
            check("arb_grant", 64'(grant_idx), 64'(rr_exp[t]));
            m_rvalid = 1'b1;
            m_rlast  = 1'b1;
            step();
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            #1;
            check("arb_gap_busy", 64'(busy), 64'd0);
            check("arb_gap_arready", 64'(s_arready), 64'd0);
            step();
        end

        // Master 1: read and write requested together -> read, idle, write
        do_reset();
        s_arvalid = 4'b0010;
        s_awvalid = 4'b0010;
        s_wvalid  = 4'b0010;
        step();
        check("rw_grant_rd", 64'(grant_idx), 64'd1);
        check("rw_rd_routing", 64'({m_arvalid, m_awvalid, m_wvalid}), 64'b100);
        check("rw_rd_s_ready", 64'({s_awready, s_wready}), 64'd0);
        step();
        s_arvalid = '0;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b1;
        step();
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        #1;
        check("rw_gap_busy", 64'(busy), 64'd0);
        check("rw_gap_awvalid", 64'(m_awvalid), 64'd0);
        step();
        check("rw_wr_busy", 64'(busy), 64'd1);
        check("rw_wr_grant", 64'(grant_idx), 64'd1);
        check("rw_wr_routing", 64'({m_arvalid, m_awvalid, m_wvalid}), 64'b011);
        check("rw_wr_awready", 64'(s_awready), 64'b0010);

        // Master 0 write, awlen=1, B delayed 10 cycles while master 0 also wants to read
        do_reset();
        s_awvalid  = 4'b0001;
        s_awlen[0] = 8'd1;
        step();
        check("wr_grant", 64'(grant_idx), 64'd0);
        check("wr_m_awid", 64'(m_awid), 64'h04);
        check("wr_m_awlen", 64'(m_awlen), 64'd1);
        step();
        s_awvalid = '0;
        s_arvalid = 4'b0001;
        for (int b = 0; b < 2; b++) begin
            s_wvalid   = 4'b0001;
            s_wdata[0] = 32'hBEEF_0000 + 32'(b);
            s_wlast    = (b == 1) ? 4'b0001 : 4'b0000;
            #1;
            check("wr_m_wdata", 64'(m_wdata), 64'(32'hBEEF_0000 + 32'(b)));
            check("wr_m_wlast", 64'(m_wlast), 64'(b == 1));
            check("wr_s_wready", 64'(s_wready), 64'b0001);
            step();
        end
        s_wvalid = '0;
        s_wlast  = '0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("wr_wait_blocked", 64'({busy, s_arready, m_arvalid}), 64'({1'b1, 4'b0000, 1'b0}));
            step();
        end
        m_bvalid = 1'b1;
        m_bid    = {2'd0, 4'h4};
        m_bresp  = 2'b10;
        #1;
        check("wr_s_bvalid", 64'(s_bvalid), 64'b0001);
        check("wr_s_bid", 64'(s_bid[0]), 64'h4);
        check("wr_s_bresp", 64'(s_bresp[0]), 64'b10);
        check("wr_m_bready", 64'(m_bready), 64'd1);
        step();
        m_bvalid = 1'b0;
        #1;
        check("wr_done_busy", 64'(busy), 64'd0);
        check("wr_done_arready", 64'(s_arready), 64'd0);
        step();
        check("wr_then_rd_arready", 64'(s_arready), 64'b0001);
        s_awlen[0] = 8'd0;

        // Reset during the second of four R beats
        do_reset();
        s_arvalid  = 4'b1000;
        s_arlen[3] = 8'd3;
        step();
        check("rstmid_grant", 64'(grant_idx), 64'd3);
        step();
        s_arvalid = '0;
        m_rvalid  = 1'b1;
        m_rdata   = 32'h1111_0000;
        m_rid     = {2'd3, 4'hB};
        step();
        m_rdata   = 32'h1111_0001;
        rst_n     = 1'b0;
        m_bvalid  = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_grant0", 64'(grant_idx), 64'd0);
        check("rstmid_s_valids", 64'({s_rvalid, s_bvalid, s_arready, s_awready, s_wready}), 64'd0);
        check("rstmid_m_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 64'd0);
        m_rvalid = 1'b0;
        m_bvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
